// File: rtl/clk_freq_meter.sv
// Clock/pulse frequency meter.
// Brings a slow asynchronous signal into the clk_in domain. Measures its
// period and high time in clk_in cycles, counts its rising edges and raises
// a sticky loss-of-signal flag when no rising edge arrives for TIMEOUT cycles.
//
// Ports:
//   clk_in     - system clock
//   rst_n      - asynchronous active-low reset
//   sig_in     - asynchronous signal under measurement
//   clr        - synchronous clear of timeout and edge_cnt
//   period     - last rising-to-rising interval (clk_in cycles)
//   high_time  - rising-to-falling interval of that same period
//   meas_valid - one-cycle pulse when period/high_time update
//   timeout    - sticky loss-of-signal flag
//   edge_cnt   - wrapping count of detected rising edges
module clk_freq_meter #(
    parameter int unsigned CNT_W       = 26,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned TIMEOUT     = 33000000,
    parameter int unsigned EDGE_W      = 16
) (
    input  logic              clk_in,
    input  logic              rst_n,
    input  logic              sig_in,
    input  logic              clr,
    output logic [CNT_W-1:0]  period,
    output logic [CNT_W-1:0]  high_time,
    output logic              meas_valid,
    output logic              timeout,
    output logic [EDGE_W-1:0] edge_cnt
);

    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

    typedef enum logic {
        IDLE,
        MEASURE
    } state_e;

    state_e                  state_q, state_d;
    logic [SYNC_STAGES-1:0]  sync_q;
    logic                    s_prev_q;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [CNT_W-1:0]        hi_tmp_q, hi_tmp_d;
    logic [CNT_W-1:0]        period_q, period_d;
    logic [CNT_W-1:0]        high_time_q, high_time_d;
    logic                    meas_valid_q, meas_valid_d;
    logic                    timeout_q, timeout_d;
    logic [EDGE_W-1:0]       edge_cnt_q, edge_cnt_d;

    logic                    s;
    logic                    rise;
    logic                    fall;
    logic                    at_limit;
    logic                    to_event;

    // Input synchronizer plus one delay flop for edge detection
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            sync_q   <= '0;
            s_prev_q <= 1'b0;
        end else begin
            sync_q   <= {sync_q[SYNC_STAGES-2:0], sig_in};
            s_prev_q <= s;
        end
    end

    assign s        = sync_q[SYNC_STAGES-1];
    assign rise     = s & ~s_prev_q;
    assign fall     = ~s & s_prev_q;
    assign at_limit = (cnt_q == TIMEOUT_CNT);

    // State and result registers
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            hi_tmp_q     <= '0;
            period_q     <= '0;
            high_time_q  <= '0;
            meas_valid_q <= 1'b0;
            timeout_q    <= 1'b0;
            edge_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            hi_tmp_q     <= hi_tmp_d;
            period_q     <= period_d;
            high_time_q  <= high_time_d;
            meas_valid_q <= meas_valid_d;
            timeout_q    <= timeout_d;
            edge_cnt_q   <= edge_cnt_d;
        end
    end

    // Next-state and measurement logic
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        hi_tmp_d     = hi_tmp_q;
        period_d     = period_q;
        high_time_d  = high_time_q;
        meas_valid_d = 1'b0;
        timeout_d    = timeout_q;
        edge_cnt_d   = edge_cnt_q;
        to_event     = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                // First edge only arms: there is no earlier edge to measure from
                if (rise) begin
                    state_d = MEASURE;
                    cnt_d   = CNT_W'(1);
                end
            end
            MEASURE: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (fall) begin
                    hi_tmp_d = cnt_q;
                end
                // A rise on the limit cycle still counts as a measurement
                if (rise) begin
                    period_d     = cnt_q;
                    high_time_d  = hi_tmp_q;
                    meas_valid_d = 1'b1;
                    cnt_d        = CNT_W'(1);
                end else if (at_limit) begin
                    state_d  = IDLE;
                    cnt_d    = '0;
                    to_event = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        // A coincident rise restarts the count at one after a clear
        if (rise) begin
            edge_cnt_d = clr ? EDGE_W'(1) : edge_cnt_q + EDGE_W'(1);
        end else if (clr) begin
            edge_cnt_d = '0;
        end

        // Setting the flag has priority over clearing it
        if (to_event) begin
            timeout_d = 1'b1;
        end else if (clr) begin
            timeout_d = 1'b0;
        end
    end

    assign period     = period_q;
    assign high_time  = high_time_q;
    assign meas_valid = meas_valid_q;
    assign timeout    = timeout_q;
    assign edge_cnt   = edge_cnt_q;

endmodule

// File: tb/tb_clk_freq_meter.sv
// Testbench for clk_freq_meter: directed scenarios plus a randomized phase,
// checked every cycle against a timestamp-based reference model.
module tb_clk_freq_meter;

    localparam int CNT_W       = 8;
    localparam int SYNC_STAGES = 2;
    localparam int TIMEOUT     = 100;
    localparam int EDGE_W      = 4;

    logic              clk_in = 1'b0;
    logic              rst_n;
    logic              sig_in;
    logic              clr;
    logic [CNT_W-1:0]  period;
    logic [CNT_W-1:0]  high_time;
    logic              meas_valid;
    logic              timeout;
    logic [EDGE_W-1:0] edge_cnt;

    clk_freq_meter #(
        .CNT_W      (CNT_W),
        .SYNC_STAGES(SYNC_STAGES),
        .TIMEOUT    (TIMEOUT),
        .EDGE_W     (EDGE_W)
    ) dut (
        .clk_in    (clk_in),
        .rst_n     (rst_n),
        .sig_in    (sig_in),
        .clr       (clr),
        .period    (period),
        .high_time (high_time),
        .meas_valid(meas_valid),
        .timeout   (timeout),
        .edge_cnt  (edge_cnt)
    );

    always #5 clk_in = ~clk_in;

    int n_assert = 0;
    int n_fail   = 0;

    // Edge bookkeeping: drv[k] is the sig_in value sampled at clock edge k
    int n    = 0;
    int base = 0;
    bit drv [0:16383];
    int rise_q[$];
    int mv_seen;
    int first_mv_edge = -1;

    // Reference model state, expressed as timestamps of detected edges
    bit m_armed;
    int m_last_rise;
    int m_hi;
    int m_period;
    int m_high;
    bit m_mv;
    bit m_to;
    int m_ec;

    function automatic bit lvl(int m);
        if (m - SYNC_STAGES <= base) return 1'b0;
        return drv[m - SYNC_STAGES];
    endfunction

    task automatic model_reset();
        m_armed = 0; m_last_rise = 0; m_hi = 0; m_period = 0; m_high = 0;
        m_mv = 0; m_to = 0; m_ec = 0;
        base = n;
    endtask

    task automatic model_update(bit c);
        bit r, f, evt;
        r   = lvl(n) && !lvl(n - 1);
        f   = !lvl(n) && lvl(n - 1);
        evt = 0;
        m_mv = 0;
        if (m_armed) begin
            if (f) m_hi = n - m_last_rise;
            if (r) begin
                m_period    = n - m_last_rise;
                m_high      = m_hi;
                m_mv        = 1;
                m_last_rise = n;
            end else if (n - m_last_rise == TIMEOUT) begin
                m_armed = 0;
                evt     = 1;
            end
        end else if (r) begin
            m_armed     = 1;
            m_last_rise = n;
        end
        if (r)      m_ec = c ? 1 : (m_ec + 1) % (1 << EDGE_W);
        else if (c) m_ec = 0;
        if (evt)    m_to = 1;
        else if (c) m_to = 0;
    endtask

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock cycle with the given inputs, then compare against the model
    task automatic step(bit v, bit c);
        sig_in = v;
        clr    = c;
        @(posedge clk_in);
        n++;
        drv[n] = v;
        if (v && !(n - 1 > base && drv[n - 1])) rise_q.push_back(n);
        model_update(c);
        #1;
        if (meas_valid === 1'b1) begin
            mv_seen++;
            if (first_mv_edge < 0) first_mv_edge = n;
        end
        check("period",     32'(period),     m_period);
        check("high_time",  32'(high_time),  m_high);
        check("meas_valid", 32'(meas_valid), 32'(m_mv));
        check("timeout",    32'(timeout),    32'(m_to));
        check("edge_cnt",   32'(edge_cnt),   m_ec);
    endtask

    task automatic wave(int per, int hi, int nper);
        for (int p = 0; p < nper; p++) begin
            for (int k = 0; k < per; k++) step(k < hi, 1'b0);
        end
    endtask

    task automatic check_all_zero(string tag);
        check({tag, "_period"},    32'(period),     0);
        check({tag, "_high_time"}, 32'(high_time),  0);
        check({tag, "_valid"},     32'(meas_valid), 0);
        check({tag, "_timeout"},   32'(timeout),    0);
        check({tag, "_edge_cnt"},  32'(edge_cnt),   0);
    endtask

    initial begin
        int L;
        bit seen;

        rst_n  = 1'b0;
        sig_in = 1'b0;
        clr    = 1'b0;
        repeat (3) @(posedge clk_in);
        #1;
        check_all_zero("reset");
        @(negedge clk_in);
        rst_n = 1'b1;
        model_reset();

        // Square wave 20/8: first valid on the second rise
        mv_seen = 0;
        step(0, 0); step(0, 0);
        wave(20, 8, 3);
        check("first_valid_latency", first_mv_edge - (rise_q[1] - 1), 3);
        check("sq_period",    32'(period),    20);
        check("sq_high_time", 32'(high_time), 8);
        check("sq_edge_cnt",  32'(edge_cnt),  3);
        check("sq_valids",    mv_seen,        2);

        // Loss of signal after the last rise
        L    = m_last_rise;
        seen = 0;
        for (int k = 0; k < 150 && !seen; k++) begin
            step(0, 0);
            if (timeout === 1'b1) seen = 1;
        end
        check("timeout_seen",  32'(seen),   1);
        check("timeout_delay", n - L,       TIMEOUT);
        check("timeout_period_kept", 32'(period), 20);

        // Re-arm: first rise gives nothing, second gives data
        mv_seen = 0;
        wave(20, 8, 2);
        check("rearm_valids", mv_seen,      1);
        check("rearm_period", 32'(period),  20);
        check("rearm_sticky", 32'(timeout), 1);

        // clr coinciding with the timeout event, then one cycle later
        L = m_last_rise;
        while (n < L + TIMEOUT - 1) step(0, 0);
        step(0, 1);
        check("clr_at_timeout", 32'(timeout), 1);
        step(0, 1);
        check("clr_after_timeout",  32'(timeout),  0);
        check("clr_after_edge_cnt", 32'(edge_cnt), 0);
        step(0, 0);

        // Rise landing exactly on the timeout limit
        mv_seen = 0;
        wave(100, 50, 3);
        check("limit_period",  32'(period),  100);
        check("limit_timeout", 32'(timeout), 0);
        check("limit_valids",  mv_seen,      2);

        // Asynchronous reset mid-period
        wave(20, 8, 2);
        for (int k = 0; k < 5; k++) step(1, 0);
        #3;
        rst_n = 1'b0;
        #1;
        check_all_zero("midrst");
        sig_in = 1'b0;
        repeat (2) @(posedge clk_in);
        #1;
        check_all_zero("midrst_hold");
        @(negedge clk_in);
        rst_n = 1'b1;
        model_reset();
        mv_seen = 0;
        wave(20, 8, 3);
        check("post_rst_valids", mv_seen,        2);
        check("post_rst_period", 32'(period),    20);
        check("post_rst_high",   32'(high_time), 8);

        // Edge counter wrap
        step(0, 1);
        for (int i = 1; i <= 17; i++) begin
            wave(6, 3, 1);
            check("edge_wrap", 32'(edge_cnt), i % (1 << EDGE_W));
        end

        // Randomized bursts, gaps and clears
        for (int seg = 0; seg < 40; seg++) begin
            int h, l;
            h = $urandom_range(1, 12);
            l = ($urandom_range(0, 7) == 0) ? $urandom_range(95, 130) : $urandom_range(1, 30);
            for (int k = 0; k < h; k++) step(1, $urandom_range(0, 15) == 0);
            for (int k = 0; k < l; k++) step(0, $urandom_range(0, 15) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
